// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles the three handshakes around the shared memory port:
//   - fetch request/response     (if_req_*, if_flush, if_rsp_*)
//   - data request/response      (d_req_*, d_rsp_*)
//   - memory port                (mem_req_*, mem_rsp_*)
//
// Modports:
//   slave  - the arbiter's view: it accepts fetch/data requests, returns their
//            responses, and drives the memory request.
//   master - the environment's view: the pipeline stages plus the memory.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Fetch side
  logic              if_req_valid;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_req_ready;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  // Data side
  logic              d_req_valid;
  logic              d_req_we;
  logic [1:0]        d_req_size;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  // Memory side
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [3:0]        mem_req_be;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;

  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_we, d_req_size, d_req_addr, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_we, d_req_size, d_req_addr, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_req_valid, mem_req_we, mem_req_be, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one single-ported unified instruction/data memory between
// the fetch stage and the memory stage. One request is in flight at a time:
// a requester is chosen in IDLE, the request is presented to memory in ISSUE,
// and the single response is routed back to its owner in WAIT.
//
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   io_bus  - mem_port_arbiter_if.slave (fetch, data and memory handshakes)
//
// Parameters:
//   ADDR_W      - address width
//   DATA_W      - data width (32: the byte enables are 4 bits)
//   MAX_DSTREAK - consecutive data grants allowed while fetch waits (1..15)
//
// Configuration macro:
//   MEM_ARB_STARVE_GUARD_EN - when defined, a data-grant streak counter lets
//   fetch win once MAX_DSTREAK data grants have gone by while it waited.
//   When undefined, data has strict priority and MAX_DSTREAK is unused.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_d;     // 0 = fetch owns the transaction, 1 = data
  logic              r_drop;        // fetch response must be discarded
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rsp_valid;
  logic [DATA_W-1:0] r_if_rsp_data;
  logic              r_d_rsp_valid;
  logic [DATA_W-1:0] r_d_rsp_data;

  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_if_hs;
  logic              w_d_hs;
  logic [3:0]        w_d_be;
  logic [DATA_W-1:0] w_d_wdata;
  logic [ADDR_W-1:0] w_word_mask;

  assign w_word_mask = ~ADDR_W'(3);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LP_MAX_DSTREAK = 4'(MAX_DSTREAK);

  logic [3:0] r_streak;

  // Fetch wins when alone, or when data has used up its streak allowance.
  assign w_grant_if = io_bus.if_req_valid &&
                      (!io_bus.d_req_valid || (r_streak == LP_MAX_DSTREAK));
`else
  logic [31:0] w_unused_max_dstreak;
  assign w_unused_max_dstreak = 32'(MAX_DSTREAK);

  assign w_grant_if = io_bus.if_req_valid && !io_bus.d_req_valid;
`endif

  assign w_grant_d = io_bus.d_req_valid && !w_grant_if;

  // Ready is only offered in IDLE and never while reset is held, so nothing
  // can be accepted by a machine that is being cleared.
  assign io_bus.if_req_ready = (r_state == ST_IDLE) && reset_n && w_grant_if;
  assign io_bus.d_req_ready  = (r_state == ST_IDLE) && reset_n && w_grant_d;

  assign w_if_hs = io_bus.if_req_valid && io_bus.if_req_ready;
  assign w_d_hs  = io_bus.d_req_valid  && io_bus.d_req_ready;

  // --------------------------------------------------------------------------
  // Data lane alignment: byte enables and store data follow the low address
  // bits; the store data arrives right-justified.
  // --------------------------------------------------------------------------
  always_comb begin
    w_d_be    = 4'b1111;
    w_d_wdata = io_bus.d_req_wdata;
    case (io_bus.d_req_size)
      2'b00: begin
        w_d_be    = 4'b0001 << io_bus.d_req_addr[1:0];
        w_d_wdata = io_bus.d_req_wdata << {io_bus.d_req_addr[1:0], 3'b000};
      end
      2'b01: begin
        w_d_be    = io_bus.d_req_addr[1] ? 4'b1100 : 4'b0011;
        w_d_wdata = io_bus.d_req_wdata << {io_bus.d_req_addr[1], 4'b0000};
      end
      default: begin
        w_d_be    = 4'b1111;
        w_d_wdata = io_bus.d_req_wdata;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_owner_d      <= 1'b0;
      r_drop         <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_be       <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= '0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_data   <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      r_streak       <= '0;
`endif
    end else begin
      // Response valids are single-cycle pulses.
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (w_if_hs) begin
            r_owner_d   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b1111;
            r_mem_addr  <= io_bus.if_req_addr & w_word_mask;
            r_mem_wdata <= '0;
            r_mem_valid <= 1'b1;
            r_state     <= ST_ISSUE;
`ifdef MEM_ARB_STARVE_GUARD_EN
            r_streak    <= '0;
`endif
          end else if (w_d_hs) begin
            r_owner_d   <= 1'b1;
            r_mem_we    <= io_bus.d_req_we;
            r_mem_be    <= w_d_be;
            r_mem_addr  <= io_bus.d_req_addr & w_word_mask;
            r_mem_wdata <= w_d_wdata;
            r_mem_valid <= 1'b1;
            r_state     <= ST_ISSUE;
`ifdef MEM_ARB_STARVE_GUARD_EN
            // The streak only grows while fetch is actually being held off.
            r_streak    <= io_bus.if_req_valid ? (r_streak + 4'd1) : 4'd0;
`endif
          end
        end

        ST_ISSUE: begin
          if (io_bus.if_flush && !r_owner_d) begin
            r_drop <= 1'b1;
          end
          if (io_bus.mem_req_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (io_bus.mem_rsp_valid) begin
            r_state <= ST_IDLE;
            r_drop  <= 1'b0;
            if (r_owner_d) begin
              r_d_rsp_valid <= 1'b1;
              r_d_rsp_data  <= r_mem_we ? '0 : io_bus.mem_rsp_data;
            end else if (!(r_drop || io_bus.if_flush)) begin
              // A flush arriving with the response still kills it.
              r_if_rsp_valid <= 1'b1;
              r_if_rsp_data  <= io_bus.mem_rsp_data;
            end
          end else if (io_bus.if_flush && !r_owner_d) begin
            r_drop <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.mem_req_valid = r_mem_valid;
  assign io_bus.mem_req_we    = r_mem_we;
  assign io_bus.mem_req_be    = r_mem_be;
  assign io_bus.mem_req_addr  = r_mem_addr;
  assign io_bus.mem_req_wdata = r_mem_wdata;
  assign io_bus.if_rsp_valid  = r_if_rsp_valid;
  assign io_bus.if_rsp_data   = r_if_rsp_data;
  assign io_bus.d_rsp_valid   = r_d_rsp_valid;
  assign io_bus.d_rsp_data    = r_d_rsp_data;

endmodule
